// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared RV32I datapath.
// MC_MEM_WAIT_EN adds the mem_ready stall input.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct_3;
  logic [6:0] funct_7;
  logic       zero;
`ifdef MC_MEM_WAIT_EN
  // mem_ready: the access presented this cycle (fetch, load or store) completes
  // in this cycle when mem_ready=1. While it is 0 the controller holds the state
  // and keeps adr_src/mem_write stable; ir_write, pc_write and instr_done stay low.
  logic       mem_ready;
`endif
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_ctrl;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
`ifdef MC_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  opcode, funct_3, funct_7, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_ctrl, reg_write, instr_done, illegal_instr
  );

  modport slave (
`ifdef MC_MEM_WAIT_EN
    output mem_ready,
`endif
    output opcode, funct_3, funct_7, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_ctrl, reg_write, instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I core, with the ALU decode folded in.
// Optional: define MC_MEM_WAIT_EN to stall FETCH, MEMREAD and MEMWRITE on mem_ready.
module multicycle_controller (
  input  logic                      clk,
  input  logic                      rstn,
  multicycle_controller_if.master   ctl,
  output logic [3:0]                dbg_state_o
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       instr_done;
    logic       in_decode;
    logic       mem_wait;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   mem_ready_w;
  logic   ready_w;
  logic   opcode_legal;
  logic   branch_alu_neg;
  logic [2:0] alu_ctrl_w;
  logic   unused_funct7_bits;

`ifdef MC_MEM_WAIT_EN
  assign mem_ready_w = ctl.mem_ready;
`else
  assign mem_ready_w = 1'b1;
`endif

  // Output decode for a state; registered one cycle ahead by evaluating it on state_d.
  function automatic ctrl_t outputs_for(input state_t s, input logic is_store);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.mem_wait   = 1'b1;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 2'b10;
        c.in_decode = 1'b1;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = is_store ? 2'b01 : 2'b00;
      end
      MEMREAD: begin
        c.adr_src  = 1'b1;
        c.mem_wait = 1'b1;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
        c.mem_wait   = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.imm_src   = 2'b11;
        c.pc_update = 1'b1;
      end
      ALUWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a  = 2'b10;
        c.alu_op     = 2'b01;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    opcode_legal = 1'b0;
    case (ctl.opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready_w) state_d = DECODE;
      DECODE: begin
        case (ctl.opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_JAL:            state_d = JAL;
          OP_BRANCH:         state_d = BRANCH;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (ctl.opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready_w) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready_w) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    ctrl_d = outputs_for(state_d, ctl.opcode == OP_STORE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FETCH;
      ctrl_q  <= outputs_for(FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // ALU decode: alu_op 00 add, 01 branch compare, 10 from funct fields.
  always_comb begin
    alu_ctrl_w     = ALU_ADD;
    branch_alu_neg = 1'b0;
    case (ctrl_q.alu_op)
      2'b01: begin
        alu_ctrl_w     = ctl.funct_3[2] ? ALU_SLT : ALU_SUB;
        branch_alu_neg = ctl.funct_3[0] ^ ctl.funct_3[2];
      end
      2'b10: begin
        case (ctl.funct_3)
          3'b000:  alu_ctrl_w = (ctl.opcode[5] & ctl.funct_7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_w = ALU_SLL;
          3'b010:  alu_ctrl_w = ALU_SLT;
          3'b011:  alu_ctrl_w = ALU_SLT;
          3'b100:  alu_ctrl_w = ALU_XOR;
          3'b101:  alu_ctrl_w = ALU_SRL;
          3'b110:  alu_ctrl_w = ALU_OR;
          default: alu_ctrl_w = ALU_AND;
        endcase
      end
      default: begin
        alu_ctrl_w     = ALU_ADD;
        branch_alu_neg = 1'b0;
      end
    endcase
  end

  // Memory-bound strobes only fire in the cycle the access completes.
  assign ready_w = ~ctrl_q.mem_wait | mem_ready_w;

  // Write enables and pulses are gated by rstn so reset kills them asynchronously.
  assign ctl.pc_write      = rstn & ((ctrl_q.pc_update & ready_w) |
                                     (ctrl_q.branch & (ctl.zero ^ branch_alu_neg)));
  assign ctl.ir_write      = rstn & ctrl_q.ir_write & ready_w;
  assign ctl.mem_write     = rstn & ctrl_q.mem_write;
  assign ctl.reg_write     = rstn & ctrl_q.reg_write;
  assign ctl.instr_done    = rstn & ctrl_q.instr_done & ready_w;
  assign ctl.illegal_instr = rstn & ctrl_q.in_decode & ~opcode_legal;
  assign ctl.adr_src       = ctrl_q.adr_src;
  assign ctl.result_src    = ctrl_q.result_src;
  assign ctl.alu_src_a     = ctrl_q.alu_src_a;
  assign ctl.alu_src_b     = ctrl_q.alu_src_b;
  assign ctl.imm_src       = ctrl_q.imm_src;
  assign ctl.alu_ctrl      = alu_ctrl_w;

  assign dbg_state_o        = state_q;
  assign unused_funct7_bits = ^{ctl.funct_7[6], ctl.funct_7[4:0]};

endmodule
